// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, trial subtraction
// through a 4-bit lookahead adder. Optional divide-by-zero shortcut under `DIV0_DETECT_EN`.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] cla_a, cla_b, cla_s;
  logic [WIDTH:0]   cla_c;
  logic             no_borrow;
  logic [WIDTH-1:0] r_new;
  logic             q_bit;

  // Trial subtraction R - D as R + ~D + 1; carries ripple between 4-bit lookahead groups.
  always_comb begin
    logic [3:0] g, p;
    logic       c;
    r_shift = {r_q, dvd_q[WIDTH-1]};
    cla_a   = r_shift[WIDTH-1:0];
    cla_b   = ~dvs_q;
    cla_s   = '0;
    cla_c   = '0;
    g       = '0;
    p       = '0;
    c       = 1'b1;
    cla_c[0] = 1'b1;
    for (int gi = 0; gi < WIDTH / 4; gi++) begin
      g = cla_a[gi*4 +: 4] & cla_b[gi*4 +: 4];
      p = cla_a[gi*4 +: 4] ^ cla_b[gi*4 +: 4];
      cla_c[gi*4+1] = g[0] | (p[0] & c);
      cla_c[gi*4+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cla_c[gi*4+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      cla_c[gi*4+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c);
      cla_s[gi*4 +: 4] = p ^ cla_c[gi*4 +: 4];
      c = cla_c[gi*4+4];
    end
    // The top bit of the shifted R sees a complemented zero, so it only extends the carry.
    no_borrow = r_shift[WIDTH] | cla_c[WIDTH];
    q_bit     = no_borrow;
    r_new     = no_borrow ? cla_s : r_shift[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          r_d     = '0;
          dvd_d   = dividend;
          dvs_d   = divisor;
          qacc_d  = '0;
          div0_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d    = r_new;
        qacc_d = {qacc_q[WIDTH-2:0], q_bit};
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = {qacc_q[WIDTH-2:0], q_bit};
          rem_d   = r_new;
        end
`ifdef DIV0_DETECT_EN
        // First RUN edge still holds the untouched dividend, so it becomes the remainder.
        if (dvs_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = '1;
          rem_d   = dvd_q;
          div0_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV0_DETECT_EN
  assign div0_err  = div0_q;
`else
  assign div0_err  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks for seq_restoring_divider (WIDTH=8).
module tb_seq_restoring_divider;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy, done, div0_err;
  logic [WIDTH-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_r[$];

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div0_err(div0_err)
  );

  always #5 clk = ~clk;

  // Called #1 after an edge; the next posedge is the start edge E0.
  task automatic issue_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    n_checks++; if (div0_err !== 1'b0) begin n_fail++; $display("FAIL reset_div0 got=%b exp=0", div0_err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    issue_start(8'd100, 8'd7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_e0 got=%b exp=1", busy); end
    for (int k = 1; k <= WIDTH; k++) begin
      @(posedge clk); #1;
      if (k < WIDTH) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0) begin
          n_fail++;
          $display("FAIL basic_run_e%0d got busy=%b done=%b q=%0d r=%0d exp busy=1 done=0 q=0 r=0",
                   k, busy, done, quotient, remainder);
        end
      end
    end
    n_checks++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL basic_done_e8 got busy=%b done=%b exp busy=0 done=1", busy, done); end
    n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
    n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    n_checks++; if (quotient !== 8'd14 || remainder !== 8'd2) begin n_fail++; $display("FAIL basic_hold got q=%0d r=%0d exp q=14 r=2", quotient, remainder); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue_start(8'd255, 8'd1);
    wait_done(lat);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, WIDTH); end
    n_checks++; if (quotient !== 8'd255 || remainder !== 8'd0) begin n_fail++; $display("FAIL b2b_res1 got q=%0d r=%0d exp q=255 r=0", quotient, remainder); end
    issue_start(8'd5, 8'd9);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
    wait_done(lat);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, WIDTH); end
    n_checks++; if (quotient !== 8'd0 || remainder !== 8'd5) begin n_fail++; $display("FAIL b2b_res2 got q=%0d r=%0d exp q=0 r=5", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div0;
    int lat;
    int exp_lat;
    logic exp_err;
`ifdef DIV0_DETECT_EN
    exp_lat = 1; exp_err = 1'b1;
`else
    exp_lat = WIDTH; exp_err = 1'b0;
`endif
    issue_start(8'h5A, 8'h00);
    wait_done(lat);
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL div0_lat got=%0d exp=%0d", lat, exp_lat); end
    n_checks++; if (quotient !== 8'hFF || remainder !== 8'h5A) begin n_fail++; $display("FAIL div0_res got q=%0h r=%0h exp q=ff r=5a", quotient, remainder); end
    n_checks++; if (div0_err !== exp_err) begin n_fail++; $display("FAIL div0_flag got=%b exp=%b", div0_err, exp_err); end
    @(posedge clk); #1;
    n_checks++; if (div0_err !== exp_err || done !== 1'b0) begin n_fail++; $display("FAIL div0_hold got err=%b done=%b exp err=%b done=0", div0_err, done, exp_err); end
  endtask

  task automatic test_ignore_start;
    int lat;
    issue_start(8'd200, 8'd10);
    n_checks++; if (div0_err !== 1'b0) begin n_fail++; $display("FAIL ignore_div0_clear got=%b exp=0", div0_err); end
    @(posedge clk); @(posedge clk); #1;
    issue_start(8'd9, 8'd3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy_e3 got=%b exp=1", busy); end
    wait_done(lat);
    n_checks++; if (lat !== WIDTH - 3) begin n_fail++; $display("FAIL ignore_lat got=%0d exp=%0d", lat, WIDTH - 3); end
    n_checks++; if (quotient !== 8'd20 || remainder !== 8'd0) begin n_fail++; $display("FAIL ignore_res got q=%0d r=%0d exp q=20 r=0", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    int lat;
    int seen_done;
    issue_start(8'd77, 8'd5);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      n_fail++;
      $display("FAIL midrst_async got busy=%b done=%b q=%0d r=%0d exp all 0", busy, done, quotient, remainder);
    end
    @(negedge clk); rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d pulses exp=0", seen_done); end
    issue_start(8'd77, 8'd5);
    wait_done(lat);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL midrst_lat got=%0d exp=%0d", lat, WIDTH); end
    n_checks++; if (quotient !== 8'd15 || remainder !== 8'd2) begin n_fail++; $display("FAIL midrst_res got q=%0d r=%0d exp q=15 r=2", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_dividend;
    int lat;
    issue_start(8'd0, 8'd3);
    wait_done(lat);
    n_checks++; if (lat !== WIDTH) begin n_fail++; $display("FAIL zero_lat got=%0d exp=%0d", lat, WIDTH); end
    n_checks++; if (quotient !== 8'd0 || remainder !== 8'd0) begin n_fail++; $display("FAIL zero_res got q=%0d r=%0d exp q=0 r=0", quotient, remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat;
    logic [WIDTH-1:0] a, b, eq, er;
    for (int i = 0; i < 400; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(1, 255));
      exp_q.push_back(a / b);
      exp_r.push_back(a % b);
      issue_start(a, b);
      wait_done(lat);
      eq = exp_q.pop_front();
      er = exp_r.pop_front();
      n_checks++;
      if (lat !== WIDTH || quotient !== eq || remainder !== er) begin
        n_fail++;
        $display("FAIL rand_%0d %0d/%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=%0d",
                 i, a, b, quotient, remainder, lat, eq, er, WIDTH);
      end
      n_checks++;
      if ((32'(quotient) * 32'(b) + 32'(remainder)) !== 32'(a) || remainder >= b) begin
        n_fail++;
        $display("FAIL rand_inv_%0d %0d/%0d got q=%0d r=%0d", i, a, b, quotient, remainder);
      end
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div0();
    test_ignore_start();
    test_mid_reset();
    test_zero_dividend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
